// File: rtl/sram_controller_pkg.sv
// Shared widths and FSM state encoding for the SRAM controller.
package sram_controller_pkg;

    localparam int unsigned LenSramAddress = 18;
    localparam int unsigned LenSramData    = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline MEM-stage side of the SRAM controller: request, load data and stall handshake.
interface sram_controller_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;

    modport master (
        output mem_read, mem_write, address, wdata,
        input  rdata, ready, freeze
    );

    modport slave (
        input  mem_read, mem_write, address, wdata,
        output rdata, ready, freeze
    );

endinterface

// File: rtl/sram_phase_counter.sv
// Per-phase cycle counter: counts 0..WAIT_CYCLES-1 while enabled and wraps on terminal count.
module sram_phase_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES);
    localparam logic [CntW-1:0] Last = CntW'(WAIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Last);

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two 16-bit async-SRAM phases, low half first.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = LenSramAddress,
    parameter int unsigned SRAM_DQ_W   = LenSramData
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    sram_controller_if.slave       mem_if,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    inout  wire  [SRAM_DQ_W-1:0]   sram_dq_io,
    output logic                   sram_we_n_o,
    output logic                   sram_oe_n_o,
    output logic                   sram_ce_n_o,
    output logic                   sram_ub_n_o,
    output logic                   sram_lb_n_o
);

    localparam int unsigned WidxW = SRAM_ADDR_W - 1;

    sram_state_e      state_q;
    logic [WidxW-1:0] widx_q, req_widx;
    logic [31:0]      wdata_q, rdata_q;
    logic             wr_q, req, in_phase, hi_phase, tc, ready;

    assign req      = mem_if.mem_read | mem_if.mem_write;
    assign req_widx = WidxW'((mem_if.address - BASE_ADDR) >> 2);
    assign in_phase = (state_q == StLo) || (state_q == StHi);
    assign hi_phase = (state_q == StHi);
    assign ready    = (state_q == StDone);

`ifdef SRAM_READ_BUFFER_EN
    logic             buf_valid_q, buf_hit;
    logic [WidxW-1:0] buf_tag_q;
    logic [31:0]      buf_data_q;

    assign buf_hit = buf_valid_q && (buf_tag_q == req_widx);
`endif

    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (~in_phase),
        .en_i  (in_phase),
        .tc_o  (tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            widx_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef SRAM_READ_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        widx_q  <= req_widx;
                        wdata_q <= mem_if.wdata;
                        wr_q    <= mem_if.mem_write;  // write wins when both are asserted
                        state_q <= StLo;
`ifdef SRAM_READ_BUFFER_EN
                        if (!mem_if.mem_write && buf_hit) begin
                            rdata_q <= buf_data_q;
                            state_q <= StDone;
                        end
`endif
                    end
                end
                StLo: begin
                    if (tc) begin
                        if (!wr_q) rdata_q[SRAM_DQ_W-1:0] <= sram_dq_io;
                        state_q <= StHi;
                    end
                end
                StHi: begin
                    if (tc) begin
                        if (!wr_q) rdata_q[2*SRAM_DQ_W-1:SRAM_DQ_W] <= sram_dq_io;
                        state_q <= StDone;
`ifdef SRAM_READ_BUFFER_EN
                        if (!wr_q) begin
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= widx_q;
                            buf_data_q  <= {sram_dq_io, rdata_q[SRAM_DQ_W-1:0]};
                        end else if (buf_valid_q && (buf_tag_q == widx_q)) begin
                            buf_data_q <= wdata_q;
                        end
`endif
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // we_n rises on the last count of a write phase so data is held past the strobe.
    assign sram_ce_n_o = ~in_phase;
    assign sram_ub_n_o = ~in_phase;
    assign sram_lb_n_o = ~in_phase;
    assign sram_oe_n_o = ~(in_phase & ~wr_q);
    assign sram_we_n_o = ~(in_phase & wr_q & ~tc);
    assign sram_addr_o = in_phase ? {widx_q, hi_phase} : '0;
    assign sram_dq_io  = (in_phase && wr_q) ?
                         (hi_phase ? wdata_q[2*SRAM_DQ_W-1:SRAM_DQ_W] : wdata_q[SRAM_DQ_W-1:0]) :
                         'z;

    assign mem_if.rdata  = rdata_q;
    assign mem_if.ready  = ready;
    assign mem_if.freeze = req & ~ready;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller with a behavioural SRAM and word-level model.
module tb_sram_controller;

    localparam int unsigned WaitCycles = 2;
    localparam int          Lat        = 1 + 2 * WaitCycles;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if mem_if();

    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_controller #(
        .BASE_ADDR  (32'd1024),
        .WAIT_CYCLES(WaitCycles)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mem_if     (mem_if),
        .sram_addr_o(sram_addr),
        .sram_dq_io (sram_dq),
        .sram_we_n_o(we_n),
        .sram_oe_n_o(oe_n),
        .sram_ce_n_o(ce_n),
        .sram_ub_n_o(ub_n),
        .sram_lb_n_o(lb_n)
    );

    // Behavioural async SRAM: write latched while we_n is low, read driven while oe_n is low.
    logic [15:0] sram_mem [0:262143];
    logic        init_mem = 1'b1;

    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 'z;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 262144; i++) sram_mem[i] <= '0;
        end else if (!ce_n && !we_n) begin
            sram_mem[sram_addr] <= sram_dq;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Word-level reference: 32-bit words indexed by word index, plus buffer tag tracking.
    logic [31:0] ref_mem [int];
`ifdef SRAM_READ_BUFFER_EN
    bit buf_valid = 1'b0;
    int buf_tag   = 0;
`endif

    function automatic int widx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h0001_FFFF);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && mem_if.ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(mem_if.ready), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ready_latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
                check("freeze_at_ready", 32'(mem_if.freeze), 32'h0);
                if (mon_e.is_read) check("rdata", mem_if.rdata, mon_e.data);
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        mem_if.mem_read  = 1'b0;
        mem_if.mem_write = 1'b0;
    endtask

    // Issue one request, optionally dropping it at cycle drop_at or scrambling inputs after accept.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input int drop_at, input bit scramble);
        exp_t e;
        int   w;
        bit   done;
        bit   held;
        w = widx_of(addr);
        @(posedge clk);
        #1;
        mem_if.mem_read  = rd;
        mem_if.mem_write = wr;
        mem_if.address   = addr;
        mem_if.wdata     = data;
        e.start   = cyc;
        e.is_read = !wr;
        e.lat     = Lat;
        if (wr) begin
            ref_mem[w] = data;
            e.data     = data;
        end else begin
            e.data = ref_rd(w);
`ifdef SRAM_READ_BUFFER_EN
            if (buf_valid && buf_tag == w) e.lat = 1;
            buf_valid = 1'b1;
            buf_tag   = w;
`endif
        end
        sb_q.push_back(e);
        done = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 4 * Lat && !done; i++) begin
            @(negedge clk);
            if (mem_if.ready) begin
                done = 1'b1;
            end else begin
                check("freeze_busy", 32'(mem_if.freeze), 32'(held));
                @(posedge clk);
                #1;
                if (drop_at > 0 && cyc - e.start == drop_at) begin
                    mem_if.mem_read  = 1'b0;
                    mem_if.mem_write = 1'b0;
                    held = 1'b0;
                end
                if (scramble) begin
                    mem_if.address = $urandom;
                    mem_if.wdata   = $urandom;
                end
            end
        end
        if (!done) check("ready_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] tmp;
        mem_if.mem_read  = 1'b0;
        mem_if.mem_write = 1'b0;
        mem_if.address   = '0;
        mem_if.wdata     = '0;
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        check("rst_ready", 32'(mem_if.ready), 32'h0);
        check("rst_freeze", 32'(mem_if.freeze), 32'h0);
        check("rst_rdata", mem_if.rdata, 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_strobes", {27'h0, we_n, oe_n, ce_n, ub_n, lb_n}, 32'h1F);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 1'b0);
        check("hw0_beef", 32'(sram_mem[0]), 32'h0000BEEF);
        check("hw1_dead", 32'(sram_mem[1]), 32'h0000DEAD);
        txn(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0);

        txn(1'b0, 1'b1, 32'd1036, 32'h12345678, 0, 1'b0);
        check("hw6", 32'(sram_mem[6]), 32'h00005678);
        check("hw7", 32'(sram_mem[7]), 32'h00001234);

        txn(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 0, 1'b0);
        check("both_hw0", 32'(sram_mem[0]), 32'h0000A5A5);
        check("both_hw1", 32'(sram_mem[1]), 32'h0000A5A5);

        // Dropped read, then an immediate follow-up accepted in the next cycle.
        txn(1'b1, 1'b0, 32'd1024, 32'h0, 2, 1'b0);
        txn(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0);
        txn(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0);
        txn(1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 0, 1'b0);
        txn(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0);
        idle();

        // Reset in the high phase of a write: only the low half reaches the SRAM.
        @(posedge clk);
        #1;
        mem_if.mem_write = 1'b1;
        mem_if.address   = 32'd1036;
        mem_if.wdata     = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_hi_addr", 32'(sram_addr), 32'd7);
        check("pre_rst_we", 32'(we_n), 32'h0);
        #1;
        rst_n            = 1'b0;
        mem_if.mem_write = 1'b0;
        #1;
        check("midrst_we", 32'(we_n), 32'h1);
        check("midrst_ce", 32'(ce_n), 32'h1);
        check("midrst_oe", 32'(oe_n), 32'h1);
        check("midrst_ready", 32'(mem_if.ready), 32'h0);
        check("midrst_rdata", mem_if.rdata, 32'h0);
        check("midrst_addr", 32'(sram_addr), 32'h0);
        tmp = ref_rd(3);
        ref_mem[3] = {tmp[31:16], 16'hF00D};
`ifdef SRAM_READ_BUFFER_EN
        buf_valid = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b1, 1'b0, 32'd1036, 32'h0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int          sel;
            int          op;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            op  = $urandom_range(0, 3);
            if (sel < 8) a = 32'd1024 + 32'(sel * 4) + 32'($urandom_range(0, 3));
            else if (sel == 8) a = 32'd1024 + 32'd524284 + 32'($urandom_range(0, 3));
            else a = 32'($urandom_range(0, 1023));
            txn(op < 2 || op == 3, op >= 2, a, $urandom,
                ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
